// File: rtl/sample_packetizer_pkg.sv
// ---------------------------------------------------------------------------
// sample_packetizer_pkg
//   Shared types and helpers for the sensor-node sample packetizer:
//   FSM state encoding, byte width and small arithmetic helpers.
// ---------------------------------------------------------------------------
`default_nettype none

package sample_packetizer_pkg;

    localparam int BYTE_W = 8;

    // Packet order on the link: header, sequence, samples, checksum.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_HDR     = 3'd4,
        ST_SEQ     = 3'd5,
        ST_DATA    = 3'd6,
        ST_CSUM    = 3'd7
    } state_e;

    // Saturating byte increment used for the dropped-tick counter.
    function automatic logic [BYTE_W-1:0] sat_inc8(input logic [BYTE_W-1:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // True while a packet is being streamed to the radio.
    function automatic logic is_tx_state(input state_e s);
        return (s == ST_HDR) || (s == ST_SEQ) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sample_packetizer_timer.sv
// ---------------------------------------------------------------------------
// sample_packetizer_timer
//   Sample-period counter. Counts 0..SAMPLE_PERIOD-1 while run is high and
//   is held at zero while run is low; tick marks the last count.
// ---------------------------------------------------------------------------
`default_nettype none

module sample_packetizer_timer #(
    parameter int SAMPLE_PERIOD = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int             CW   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CW-1:0]  LAST = CW'(SAMPLE_PERIOD - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: wrap at the period end, clear whenever sampling is stopped.
    always_comb begin
        count_d = count_q;
        if (!run) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // Period counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = run && (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/sample_packetizer.sv
// ---------------------------------------------------------------------------
// sample_packetizer
//   Duty-cycles the sensor enable, captures PKT_LEN samples and streams
//   them as header / sequence / samples / checksum over valid-ready.
// ---------------------------------------------------------------------------
`default_nettype none

module sample_packetizer
    import sample_packetizer_pkg::*;
#(
    parameter logic [BYTE_W-1:0] NODE_ID       = 8'h01,
    parameter int                PKT_LEN       = 4,
    parameter int                SAMPLE_PERIOD = 100,
    parameter int                SETTLE        = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [BYTE_W-1:0] sensor_data,
    output logic              sensor_en,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              busy,
    output logic [BYTE_W-1:0] dropped_cnt
);

    localparam int                IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int                SET_W    = $clog2(SETTLE + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PKT_LEN - 1);
    localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE - 1);

    logic tick;

    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   cnt_q,       cnt_d;       // capture slot, reused as DATA index
    logic [SET_W-1:0]   settle_q,    settle_d;
    logic [BYTE_W-1:0]  seq_q,       seq_d;
    logic [BYTE_W-1:0]  sum_q,       sum_d;       // running sum of captured samples
    logic [BYTE_W-1:0]  dropped_q,   dropped_d;
    logic               sensor_en_q, sensor_en_d;
    logic               capture_en;
    logic               accept;
    logic [BYTE_W-1:0]  samp_buf_q [0:PKT_LEN-1];

    sample_packetizer_timer #(
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .tick  (tick)
    );

    assign accept = tx_valid && tx_ready;

    // Next-state, counters and link outputs; link outputs depend only on state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        settle_d   = settle_q;
        seq_d      = seq_q;
        sum_d      = sum_q;
        dropped_d  = dropped_q;
        capture_en = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        tx_last    = 1'b0;

        // A tick that lands while streaming cannot be serviced.
        if (tick && is_tx_state(state_q)) begin
            dropped_d = sat_inc8(dropped_q);
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                settle_d = '0;
                sum_d    = '0;
                if (run) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!run) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    sum_d   = '0;
                end else if (tick) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            end
            ST_SETTLE: begin
                if (!run) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    sum_d   = '0;
                end else if (settle_q == SET_LAST) begin
                    state_d  = ST_CAPTURE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (!run) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    sum_d   = '0;
                end else begin
                    capture_en = 1'b1;
                    sum_d      = sum_q + sensor_data;
                    if (cnt_q == IDX_LAST) begin
                        state_d = ST_HDR;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = NODE_ID;
                if (accept) begin
                    state_d = ST_SEQ;
                end
            end
            ST_SEQ: begin
                tx_valid = 1'b1;
                tx_data  = seq_q;
                if (accept) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_valid = 1'b1;
                tx_data  = samp_buf_q[cnt_q];
                if (accept) begin
                    if (cnt_q == IDX_LAST) begin
                        state_d = ST_CSUM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_CSUM: begin
                tx_valid = 1'b1;
                tx_last  = 1'b1;
                tx_data  = NODE_ID + seq_q + sum_q;
                if (accept) begin
                    seq_d   = seq_q + 8'd1;
                    sum_d   = '0;
                    state_d = run ? ST_WAIT : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sensor_en_d = (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            settle_q    <= '0;
            seq_q       <= '0;
            sum_q       <= '0;
            dropped_q   <= '0;
            sensor_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            settle_q    <= settle_d;
            seq_q       <= seq_d;
            sum_q       <= sum_d;
            dropped_q   <= dropped_d;
            sensor_en_q <= sensor_en_d;
        end
    end

    // Sample buffer: one slot written per capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PKT_LEN; i++) begin
                samp_buf_q[i] <= '0;
            end
        end else if (capture_en) begin
            samp_buf_q[cnt_q] <= sensor_data;
        end
    end

    assign sensor_en   = sensor_en_q;
    assign dropped_cnt = dropped_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sample_packetizer.sv
// ---------------------------------------------------------------------------
// tb_sample_packetizer
//   Randomized bench with a transaction-level reference model: expected
//   packets are built from the samples presented on capture cycles.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sample_packetizer;

    localparam logic [7:0] NODE_ID = 8'hA5;
    localparam int         PKT_LEN = 4;
    localparam int         PERIOD  = 16;
    localparam int         SETTLE  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [7:0] sensor_data;
    logic       sensor_en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    logic       busy;
    logic [7:0] dropped_cnt;

    sample_packetizer #(
        .NODE_ID       (NODE_ID),
        .PKT_LEN       (PKT_LEN),
        .SAMPLE_PERIOD (PERIOD),
        .SETTLE        (SETTLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .sensor_data (sensor_data),
        .sensor_en   (sensor_en),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_last     (tx_last),
        .busy        (busy),
        .dropped_cnt (dropped_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [7:0] exp_q[$];     // bytes still owed to the radio
    logic [7:0] samp_q[$];    // samples collected for the packet in progress
    logic [7:0] rx_log[$];    // bytes observed being accepted
    logic [7:0] dir_q[$];     // directed sample values for the next captures
    int         tcount;
    int         en_left;
    logic [7:0] seq_m;
    logic [7:0] drop_m;
    logic       busy_m;
    int         pkts_done = 0;
    int         cyc = 0;

    // Stimulus controls.
    int run_mode   = 0;   // 0 run=1, 1 random drops, 2 run=0
    int ready_mode = 0;   // 0 ready=1, 1 random with stalls, 2 ready=0
    int run_hold   = 0;
    int stall_left = 0;
    bit stall_arm  = 0;

    logic [7:0] exp_pkt1 [7] = '{8'hA5, 8'h00, 8'h00, 8'h0F, 8'h50, 8'h5F, 8'h63};
    logic [7:0] exp_pkt2 [7] = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        samp_q.delete();
        dir_q.delete();
        tcount     = 0;
        en_left    = 0;
        seq_m      = 8'h00;
        drop_m     = 8'h00;
        busy_m     = 1'b0;
        stall_left = 0;
        stall_arm  = 0;
        run_hold   = 0;
    endtask

    // Compare this cycle's outputs, then advance the model by one cycle.
    task automatic model_step();
        logic       tick;
        logic [7:0] cs;
        check("tx_valid",    tx_valid,    exp_q.size() != 0);
        if (exp_q.size() != 0) check("tx_data", tx_data, exp_q[0]);
        check("tx_last",     tx_last,     exp_q.size() == 1);
        check("sensor_en",   sensor_en,   en_left > 0);
        check("busy",        busy,        busy_m);
        check("dropped_cnt", dropped_cnt, drop_m);

        tick   = run && (tcount == PERIOD - 1);
        tcount = run ? (tcount + 1) % PERIOD : 0;

        if (exp_q.size() != 0) begin
            if (tick && drop_m != 8'hFF) drop_m = drop_m + 8'd1;
            if (tx_ready) begin
                rx_log.push_back(tx_data);
                if (exp_q.size() == 1) begin
                    seq_m = seq_m + 8'd1;
                    pkts_done++;
                end
                void'(exp_q.pop_front());
            end
        end else if (!run) begin
            en_left = 0;
            samp_q.delete();
        end else if (en_left > 0) begin
            en_left--;
            if (en_left == 0) begin
                samp_q.push_back(sensor_data);
                if (samp_q.size() == PKT_LEN) begin
                    cs = NODE_ID + seq_m;
                    foreach (samp_q[i]) cs = cs + samp_q[i];
                    exp_q.push_back(NODE_ID);
                    exp_q.push_back(seq_m);
                    foreach (samp_q[i]) exp_q.push_back(samp_q[i]);
                    exp_q.push_back(cs);
                    samp_q.delete();
                end
            end
        end else if (tick) begin
            en_left = SETTLE + 1;
        end

        busy_m = (exp_q.size() != 0) || run;
    endtask

    task automatic drive();
        case (run_mode)
            0: run = 1'b1;
            2: run = 1'b0;
            default: begin
                if (run_hold > 0) begin
                    run = 1'b0;
                    run_hold--;
                end else if ($urandom_range(0, 149) == 0) begin
                    run      = 1'b0;
                    run_hold = $urandom_range(0, 25);
                end else begin
                    run = 1'b1;
                end
            end
        endcase

        if (stall_arm && exp_q.size() == 4) begin
            stall_arm  = 0;
            stall_left = 20;
        end
        if (stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left--;
        end else begin
            case (ready_mode)
                0: tx_ready = 1'b1;
                2: tx_ready = 1'b0;
                default: begin
                    if (exp_q.size() >= 2 && exp_q.size() <= 5 && $urandom_range(0, 39) == 0) begin
                        tx_ready   = 1'b0;
                        stall_left = 19;
                    end else begin
                        tx_ready = ($urandom_range(0, 3) != 0);
                    end
                end
            endcase
        end

        if (en_left == 1 && dir_q.size() != 0) sensor_data = dir_q.pop_front();
        else                                    sensor_data = 8'($urandom_range(0, 255));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        model_step();
        cyc++;
    endtask

    task automatic run_until_pkts(input int target, input int budget);
        int start;
        start = cyc;
        while (pkts_done < target && (cyc - start) < budget) step();
        check("pkt_timeout", pkts_done, target);
    endtask

    task automatic check_log(input string tag, input logic [7:0] exp [7]);
        check({tag, "_len"}, rx_log.size(), 7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("%s_byte%0d", tag, i), rx_log[i], exp[i]);
        end
    endtask

    initial begin
        int start;
        rst_n       = 1'b0;
        run         = 1'b0;
        tx_ready    = 1'b0;
        sensor_data = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid",  tx_valid,    1'b0);
        check("rst_tx_data",   tx_data,     8'h00);
        check("rst_tx_last",   tx_last,     1'b0);
        check("rst_sensor_en", sensor_en,   1'b0);
        check("rst_busy",      busy,        1'b0);
        check("rst_dropped",   dropped_cnt, 8'h00);
        rst_n = 1'b1;
        model_step();

        // Basic packet with spec sample values.
        dir_q = '{8'h00, 8'h0F, 8'h50, 8'h5F};
        rx_log.delete();
        run_until_pkts(1, 300);
        check_log("basic", exp_pkt1);
        check("basic_dropped", dropped_cnt, 8'h00);

        // Second packet: all-ones samples, sequence 1.
        dir_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        rx_log.delete();
        run_until_pkts(2, 300);
        check_log("second", exp_pkt2);

        // 20-cycle backpressure in the middle of DATA.
        stall_arm = 1;
        rx_log.delete();
        run_until_pkts(3, 300);
        check("bp_len",     rx_log.size(), 7);
        check("bp_dropped", dropped_cnt,   8'h01);

        // Stop after two captures, then restart.
        start = cyc;
        while (samp_q.size() < 2 && (cyc - start) < 300) step();
        check("rundrop_reach", samp_q.size(), 2);
        run_mode = 2;
        repeat (10) step();
        check("rundrop_busy",      busy,      1'b0);
        check("rundrop_sensor_en", sensor_en, 1'b0);
        run_mode = 0;
        rx_log.delete();
        run_until_pkts(4, 300);
        check("rundrop_seq", rx_log[1], 8'h03);

        // Randomized run / ready traffic.
        run_mode   = 1;
        ready_mode = 1;
        run_until_pkts(pkts_done + 40, 12000);
        run_mode   = 0;
        run_hold   = 0;

        // Long stall to saturate the dropped counter.
        ready_mode = 2;
        repeat (4400) step();
        check("drop_sat", dropped_cnt, 8'hFF);
        ready_mode = 0;

        // Enough packets to wrap the sequence number.
        run_until_pkts(pkts_done + 260, 20000);

        // Reset while streaming samples.
        start = cyc;
        while (exp_q.size() != 4 && (cyc - start) < 300) step();
        check("rst_reach_data", exp_q.size(), 4);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        run      = 1'b0;
        tx_ready = 1'b0;
        #1;
        check("midrst_tx_valid",  tx_valid,  1'b0);
        check("midrst_sensor_en", sensor_en, 1'b0);
        check("midrst_busy",      busy,      1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check("midrst_dropped", dropped_cnt, 8'h00);
        model_step();
        rx_log.delete();
        run_until_pkts(pkts_done + 1, 300);
        check("midrst_seq", rx_log[1], 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
